mem_access_unit: RTL

//  MEM-stage data-bus master sitting directly upstream of the load-data extractor. Takes load/store

---
 rtl/mips_mem_pkg.sv | 28 ++
 rtl/mem_access_unit_if.sv | 30 +++
 rtl/mem_access_unit_store_lane_align.sv | 52 +++++
 rtl/mem_access_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
//  Shared definitions for the MEM-stage memory path: MemDataControl access-size
//  encodings (also used by the load-data extractor), the memory access unit FSM
//  state type, and the default bus timeout.
// -----------------------------------------------------------------------------
package mips_mem_pkg;

   // MemDataControl encodings; every other code means "no memory access"
   localparam logic [2:0] MDC_BYTE = 3'b001;
   localparam logic [2:0] MDC_HALF = 3'b010;
   localparam logic [2:0] MDC_WORD = 3'b011;

   // Default number of BUSY cycles allowed before an access is aborted
   localparam int DEFAULT_TIMEOUT_CYCLES = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mau_state_e;

   // True when the size code names a real byte/half/word access
   function automatic logic is_access_size(input logic [2:0] mdc);
      return (mdc == MDC_BYTE) || (mdc == MDC_HALF) || (mdc == MDC_WORD);
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
//  Word-addressed data bus with a req/ack handshake.
//   BusReq    master->slave  access request, held until completion
//   BusWE     master->slave  write strobe
//   BusAddr   master->slave  word-aligned byte address
//   BusByteEn master->slave  byte lanes written (zero on loads)
//   BusWData  master->slave  lane-replicated store data
//   BusAck    slave->master  one-cycle completion pulse
//   BusRData  slave->master  read word, valid with BusAck
// -----------------------------------------------------------------------------
interface mem_access_unit_if;
   logic        BusReq;
   logic        BusWE;
   logic [31:0] BusAddr;
   logic [3:0]  BusByteEn;
   logic [31:0] BusWData;
   logic        BusAck;
   logic [31:0] BusRData;

   modport master (
      output BusReq, BusWE, BusAddr, BusByteEn, BusWData,
      input  BusAck, BusRData
   );

   modport slave (
      input  BusReq, BusWE, BusAddr, BusByteEn, BusWData,
      output BusAck, BusRData
   );
endinterface

// File: rtl/mem_access_unit_store_lane_align.sv
// -----------------------------------------------------------------------------
// store_lane_align
//  Combinational store lane steering and alignment check.
//   addr_lo    in   2   byte address bits [1:0]
//   size       in   3   MemDataControl size code
//   wd         in   32  store source value
//   byteen     out  4   byte lanes to write
//   wdata      out  32  store data replicated across all lanes
//   misaligned out  1   half on odd address or word not on a 4-byte boundary
//  Non-access size codes produce all-zero outputs.
// -----------------------------------------------------------------------------
module store_lane_align
   import mips_mem_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  size,
   input  logic [31:0] wd,
   output logic [3:0]  byteen,
   output logic [31:0] wdata,
   output logic        misaligned
);

   // Lane enables, replicated data and alignment per access size
   always_comb begin
      byteen     = 4'b0000;
      wdata      = 32'h0000_0000;
      misaligned = 1'b0;
      case (size)
         MDC_BYTE: begin
            byteen     = 4'b0001 << addr_lo;
            wdata      = {4{wd[7:0]}};
            misaligned = 1'b0;
         end
         MDC_HALF: begin
            byteen     = 4'b0011 << {addr_lo[1], 1'b0};
            wdata      = {2{wd[15:0]}};
            misaligned = addr_lo[0];
         end
         MDC_WORD: begin
            byteen     = 4'b1111;
            wdata      = wd;
            misaligned = |addr_lo;
         end
         default: begin
            byteen     = 4'b0000;
            wdata      = 32'h0000_0000;
            misaligned = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//  MEM-stage data-bus master. Accepts a load/store from EX/MEM, runs one bus
//  transaction, stalls the pipeline until it completes and hands the raw read
//  word (with byte offset and size) to the load-data extractor.
//   clk, reset                     clock, synchronous active-high reset
//   MemReq, MemWrite               access present / store select
//   MemDataControl                 size code (byte/half/word, else no access)
//   ALUResult, WriteData           byte address / store source value
//   Stall                          combinational pipeline freeze
//   AddrExc                        combinational misaligned-access flag
//   bus                            data bus master port
//   RawMemoryData, RawAddrLow,
//   RawDataControl                 registered result for the extractor
//   RawValid                       one-cycle completion pulse
//   BusErr                         one-cycle timeout flag alongside RawValid
// -----------------------------------------------------------------------------
module mem_access_unit
   import mips_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     MemReq,
   input  logic                     MemWrite,
   input  logic [2:0]               MemDataControl,
   input  logic [31:0]              ALUResult,
   input  logic [31:0]              WriteData,
   output logic                     Stall,
   output logic                     AddrExc,
   mem_access_unit_if.master        bus,
   output logic [31:0]              RawMemoryData,
   output logic [1:0]               RawAddrLow,
   output logic [2:0]               RawDataControl,
   output logic                     RawValid,
   output logic                     BusErr
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   mau_state_e  state_r;
   mau_state_e  state_s;
   logic [CW-1:0] cnt_r;

   logic        legal_s;
   logic        misaligned_s;
   logic        start_s;
   logic        timeout_s;
   logic [3:0]  lane_byteen_s;
   logic [31:0] lane_wdata_s;

   logic        bus_req_r;
   logic        bus_we_r;
   logic        we_r;
   logic [31:0] bus_addr_r;
   logic [3:0]  bus_byteen_r;
   logic [31:0] bus_wdata_r;

   store_lane_align u_align (
      .addr_lo    (ALUResult[1:0]),
      .size       (MemDataControl),
      .wd         (WriteData),
      .byteen     (lane_byteen_s),
      .wdata      (lane_wdata_s),
      .misaligned (misaligned_s)
   );

   assign legal_s   = MemReq & is_access_size(MemDataControl);
   assign start_s   = (state_r == ST_IDLE) & legal_s & ~misaligned_s;
   assign timeout_s = (cnt_r == CW'(TIMEOUT_CYCLES - 1));

   // Bus side is driven only from latched values so it stays stable while BUSY
   assign bus.BusReq    = bus_req_r;
   assign bus.BusWE     = bus_we_r;
   assign bus.BusAddr   = bus_addr_r;
   assign bus.BusByteEn = bus_byteen_r;
   assign bus.BusWData  = bus_wdata_r;

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state, stall and address-exception decode
   always_comb begin
      state_s = state_r;
      Stall   = 1'b0;
      AddrExc = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // A misaligned request is flagged here and never leaves IDLE
            AddrExc = legal_s & misaligned_s;
            if (start_s) begin
               state_s = ST_BUSY;
               Stall   = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            Stall = 1'b1;
            if (bus.BusAck || timeout_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_BUSY;
            end
         end
         ST_DONE: begin
            // Stall drops here so the pipeline advances exactly once
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Request latch, bus drive, timeout counter and Raw* result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r          <= '0;
         bus_req_r      <= 1'b0;
         bus_we_r       <= 1'b0;
         we_r           <= 1'b0;
         bus_addr_r     <= 32'h0000_0000;
         bus_byteen_r   <= 4'b0000;
         bus_wdata_r    <= 32'h0000_0000;
         RawMemoryData  <= 32'h0000_0000;
         RawAddrLow     <= 2'b00;
         RawDataControl <= 3'b000;
         RawValid       <= 1'b0;
         BusErr         <= 1'b0;
      end else begin
         RawValid <= 1'b0;
         BusErr   <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  cnt_r          <= '0;
                  bus_req_r      <= 1'b1;
                  bus_we_r       <= MemWrite;
                  we_r           <= MemWrite;
                  bus_addr_r     <= {ALUResult[31:2], 2'b00};
                  bus_byteen_r   <= MemWrite ? lane_byteen_s : 4'b0000;
                  bus_wdata_r    <= MemWrite ? lane_wdata_s : 32'h0000_0000;
                  RawAddrLow     <= ALUResult[1:0];
                  RawDataControl <= MemDataControl;
               end else begin
                  bus_req_r <= 1'b0;
               end
            end
            ST_BUSY: begin
               // Ack takes priority over a timeout in the same cycle
               if (bus.BusAck) begin
                  if (!we_r) begin
                     RawMemoryData <= bus.BusRData;
                  end else begin
                     RawMemoryData <= RawMemoryData;
                  end
                  bus_req_r <= 1'b0;
                  bus_we_r  <= 1'b0;
                  RawValid  <= 1'b1;
               end else if (timeout_s) begin
                  RawMemoryData <= 32'h0000_0000;
                  bus_req_r     <= 1'b0;
                  bus_we_r      <= 1'b0;
                  RawValid      <= 1'b1;
                  BusErr        <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            ST_DONE: begin
               bus_req_r <= 1'b0;
               bus_we_r  <= 1'b0;
            end
            default: begin
               bus_req_r <= 1'b0;
               bus_we_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule
